// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter that shares one mux/datapath among N requesters.
// Grants are registered and may be held for up to MAX_HOLD cycles before rotation.
module rr_mux_arbiter #(
   parameter int N = 4,
   parameter int MAX_HOLD = 4,
   localparam int SELW = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N-1:0]    req,
   output logic [N-1:0]    grant,
   output logic [SELW-1:0] sel,
   output logic            en,
   output logic            gnt_new
);

   localparam int HW = $clog2(MAX_HOLD) + 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t          state, state_nxt;
   logic [SELW-1:0] last, last_nxt, sel_nxt, win, idx;
   logic [HW-1:0]   hold_cnt, hold_nxt;
   logic            new_nxt;

   // Searching downward leaves the nearest requester after 'last' as the winner.
   // The owner itself is the final candidate, so a lone holder is re-granted.
   always_comb begin
      win = last;
      idx = '0;
      for (int unsigned k = N; k > 0; k--) begin
         idx = SELW'((32'(last) + k) % N);
         if (req[idx]) win = idx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         sel      <= '0;
         last     <= SELW'(N - 1);
         hold_cnt <= '0;
         gnt_new  <= 1'b0;
      end else begin
         state    <= state_nxt;
         sel      <= sel_nxt;
         last     <= last_nxt;
         hold_cnt <= hold_nxt;
         gnt_new  <= new_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      sel_nxt   = sel;
      last_nxt  = last;
      hold_nxt  = hold_cnt;
      new_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (|req) begin
               state_nxt = GRANT;
               sel_nxt   = win;
               last_nxt  = win;
               hold_nxt  = '0;
               new_nxt   = 1'b1;
            end
         end
         GRANT: begin
            if (req[sel] && hold_cnt != HOLD_LAST) begin
               hold_nxt = hold_cnt + HW'(1);
            end else if (|req) begin
               sel_nxt  = win;
               last_nxt = win;
               hold_nxt = '0;
               new_nxt  = 1'b1;
            end else begin
               state_nxt = IDLE;
               hold_nxt  = '0;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      grant = '0;
      en    = (state == GRANT);
      if (en) grant[sel] = 1'b1;
   end

   a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant));
   a_en:     assert property (@(posedge clk) disable iff (!rst_n) en == (|grant));
   a_hold:   assert property (@(posedge clk) disable iff (!rst_n) hold_cnt <= HOLD_LAST);

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one mux/datapath resource among N requesters.
- Drives the resource's select (sel) and enable (en), and returns a one-hot grant to the requesters.
- Grants can be held for a bounded burst, up to MAX_HOLD consecutive cycles, before rotation is forced.
- Sits between requesting units and the shared mux (d/s/en/z1 style datapath); fully synchronous to one clock.

Parameters:
- N, 4, number of requesters; legal range N >= 2.
- MAX_HOLD, 4, maximum consecutive cycles one requester may hold the grant while others wait; legal range MAX_HOLD >= 1.
- SELW, $clog2(N), width of sel; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  N  request vector; bit i high = requester i wants the resource.
- grant  output  N  one-hot grant, registered; all-zero when idle.
- sel  output  SELW  binary index of the granted requester; drives the mux select.
- en  output  1  resource enable; high exactly when grant != 0.
- gnt_new  output  1  one-cycle pulse on the first cycle of each new grant (new owner, or re-grant after a forced rotation check).

Behaviour:
- Reset (rst_n low, takes effect immediately regardless of clk):
  - grant=0, sel=0, en=0, gnt_new=0.
  - State=IDLE, hold_cnt=0, last pointer=N-1, so req[0] has first priority.
- Winner function: first i with req[i]=1, searching (last+1) mod N upward with wrap-around.
- All outputs are registered. Latency is 1 cycle from req sampled to grant/sel/en valid.
- IDLE:
  - req==0: stay in IDLE; outputs 0.
  - req!=0: go to GRANT; grant=onehot(winner), sel=winner, en=1, gnt_new=1, last=winner, hold_cnt=0.
- GRANT, evaluated each edge for current owner s=sel:
  - req[s]=1 and hold_cnt<MAX_HOLD-1: keep grant; hold_cnt+1; gnt_new=0.
  - req[s]=1 and hold_cnt==MAX_HOLD-1, other requests pending: rotate to the winner after s; hold_cnt=0; gnt_new=1.
  - req[s]=1 and hold_cnt==MAX_HOLD-1, no other request: re-grant s with no bubble; hold_cnt=0; gnt_new=1.
  - req[s]=0 and any other req: switch directly to the winner after s in the same edge (no idle bubble); hold_cnt=0; gnt_new=1.
  - req==0: go to IDLE; grant=0, en=0, sel holds its last value, gnt_new=0.
- No preemption. A new higher-priority request never interrupts a grant before release or hold expiry.
- Simultaneous release and new requests are resolved in the same edge, with the pointer starting after the released owner.
- MAX_HOLD=1: rotation is checked every cycle, giving a strict per-cycle round robin.
- hold_cnt width is $clog2(MAX_HOLD)+1 and it never exceeds MAX_HOLD-1.
- Invariants: grant is always one-hot or zero; grant[sel]==en when en=1.
- Reset asserted mid-burst clears everything asynchronously. After release, arbitration restarts with req[0] priority.
- No X propagation: req bits are treated as 0/1; SVA checks one-hot and en==|grant.

Test Plan (N=4, MAX_HOLD=4):
1. Reset: hold rst_n=0 with req=1111 -> grant=0000, sel=0, en=0, gnt_new=0 throughout. Release rst_n -> next edge grant=0001, sel=0, gnt_new=1.
2. Single requester: req=0100 held for 10 cycles -> grant=0100 continuously from cycle 1, en=1, sel=2. gnt_new pulses at cycles 1, 5 and 9 (re-grants); no gap in en.
3. Full contention: req=1111 steady -> grant sequence 0001x4, 0010x4, 0100x4, 1000x4, 0001...; gnt_new high on the first cycle of each group.
4. Early release: owner 1 (grant=0010) drops req[1] after 2 cycles while req=1001 -> next edge grant=1000, sel=3, en stays 1, gnt_new=1.
5. Idle and pointer: after owner 3 releases with req=0000 -> grant=0000, en=0. Then req=1111 -> grant=0001 (search starts after 3, wraps to 0).
6. Reset mid-burst: owner 2 at hold_cnt=2, pull rst_n low between edges -> outputs 0 immediately, before the next clk edge. After release with req=0110 -> grant=0010.
